// File: rtl/bram_pkg.sv
// bram_pkg: shared definitions for the bram_dp_be memory.
// Holds the width helpers (address width and byte-lane count) and the
// clear-sequencer state type.
package bram_pkg;

  // Number of address bits needed to index 'value' words.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Number of 8-bit lanes in a data word.
  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

  // CLEAR: zero-fill sweep in progress; RUN: normal port access.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

endpackage

// File: rtl/bram_clear_ctrl.sv
// bram_clear_ctrl: post-reset zero-fill sequencer.
// Sweeps a counter over every word address, one word per cycle, then
// parks in RUN.
// Ports:
//   clk, rst       - clock and asynchronous active-high reset
//   busy           - high while the sweep runs; rises with rst
//   clr_addr       - word address being cleared this cycle
//   clr_we         - clear write strobe (all lanes, data 0)
module bram_clear_ctrl
  import bram_pkg::*;
#(
  parameter int DEPTH          = 4096,
  parameter int AW             = 12,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic [AW-1:0] clr_addr,
  output logic          clr_we
);

  localparam clr_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic       RESET_BUSY = (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  // Next-state, counter and busy computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          state_d = CLEAR;
          cnt_d   = cnt_q + AW'(1);
        end
      end
      RUN: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
    // Busy is registered so it drops on the same edge that clears the last word.
    busy_d = (state_d == CLEAR);
  end

  // State, counter and busy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      busy_q  <= RESET_BUSY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign clr_addr = cnt_q;
  assign clr_we   = (state_q == CLEAR);

endmodule

// File: rtl/bram_dp_be.sv
// bram_dp_be: single-clock true dual-port RAM with per-byte write enables.
// Read-first on both ports, optional output register (OUT_REG), one-cycle
// valid strobes and a zero-fill sweep after reset (CLEAR_ON_RESET).
// Ports:
//   Clock, Reset           - clock and asynchronous active-high reset
//   Busy                   - clear sweep running; port accesses ignored
//   AddressX, DataInX      - word address and write data (X = A, B)
//   ByteEnX                - byte-lane write enables
//   ClockEnX, WriteX       - access request and write/read select
//   DataOutX, ValidX       - read data and its one-cycle strobe
module bram_dp_be
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 4096,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = clog2(DEPTH),
  localparam int BW            = lane_count(DATA_WIDTH)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic                  Busy,
  input  logic [AW-1:0]         AddressA,
  input  logic [AW-1:0]         AddressB,
  input  logic [DATA_WIDTH-1:0] DataInA,
  input  logic [DATA_WIDTH-1:0] DataInB,
  input  logic [BW-1:0]         ByteEnA,
  input  logic [BW-1:0]         ByteEnB,
  input  logic                  ClockEnA,
  input  logic                  ClockEnB,
  input  logic                  WriteA,
  input  logic                  WriteB,
  output logic [DATA_WIDTH-1:0] DataOutA,
  output logic [DATA_WIDTH-1:0] DataOutB,
  output logic                  ValidA,
  output logic                  ValidB
);

  logic            clr_busy;
  logic [AW-1:0]   clr_addr;
  logic            clr_we;

  bram_clear_ctrl #(
    .DEPTH         (DEPTH),
    .AW            (AW),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .clk     (Clock),
    .rst     (Reset),
    .busy    (clr_busy),
    .clr_addr(clr_addr),
    .clr_we  (clr_we)
  );

  assign Busy = clr_busy;

  logic [BW-1:0][7:0]    mem [DEPTH];

  logic                  acc_a, acc_b;
  logic [AW-1:0]         waddr_a;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic [BW-1:0]         lane_we_a, lane_we_b;

  // Port gating and the clear mux in front of port A's write path.
  always_comb begin
    acc_a = ClockEnA & ~clr_busy;
    acc_b = ClockEnB & ~clr_busy;
    if (clr_we) begin
      waddr_a   = clr_addr;
      wdata_a   = '0;
      lane_we_a = '1;
    end else begin
      waddr_a   = AddressA;
      wdata_a   = DataInA;
      lane_we_a = (acc_a & WriteA) ? ByteEnA : '0;
    end
    lane_we_b = (acc_b & WriteB) ? ByteEnB : '0;
  end

  // Lane-enabled array write; A is applied after B so A wins shared lanes.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < BW; i++) begin
      if (lane_we_b[i]) begin
        mem[AddressB][i] <= DataInB[8*i +: 8];
      end
      if (lane_we_a[i]) begin
        mem[waddr_a][i] <= wdata_a[8*i +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic                  vld_a_q, vld_a_d, vld_b_q, vld_b_d;

  // Read stage: capture the pre-write word on any access, hold otherwise.
  always_comb begin
    if (acc_a) begin
      rd_a_d = mem[AddressA];
    end else begin
      rd_a_d = rd_a_q;
    end
    if (acc_b) begin
      rd_b_d = mem[AddressB];
    end else begin
      rd_b_d = rd_b_q;
    end
    vld_a_d = acc_a;
    vld_b_d = acc_b;
  end

  // Read stage registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      vld_a_q <= 1'b0;
      vld_b_q <= 1'b0;
    end else begin
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      vld_a_q <= vld_a_d;
      vld_b_q <= vld_b_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
    logic                  vout_a_q, vout_a_d, vout_b_q, vout_b_d;

    // Output stage follows the read stage only when it carried new data.
    always_comb begin
      if (vld_a_q) begin
        dout_a_d = rd_a_q;
      end else begin
        dout_a_d = dout_a_q;
      end
      if (vld_b_q) begin
        dout_b_d = rd_b_q;
      end else begin
        dout_b_d = dout_b_q;
      end
      vout_a_d = vld_a_q;
      vout_b_d = vld_b_q;
    end

    // Output stage registers.
    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        dout_a_q <= '0;
        dout_b_q <= '0;
        vout_a_q <= 1'b0;
        vout_b_q <= 1'b0;
      end else begin
        dout_a_q <= dout_a_d;
        dout_b_q <= dout_b_d;
        vout_a_q <= vout_a_d;
        vout_b_q <= vout_b_d;
      end
    end

    assign DataOutA = dout_a_q;
    assign DataOutB = dout_b_q;
    assign ValidA   = vout_a_q;
    assign ValidB   = vout_b_q;
  end else begin : g_no_out_reg
    assign DataOutA = rd_a_q;
    assign DataOutB = rd_b_q;
    assign ValidA   = vld_a_q;
    assign ValidB   = vld_b_q;
  end

endmodule

// File: doc/bram_dp_be.md
# bram_dp_be

Parametrised single-clock true dual-port block RAM with per-byte write enables, optional output pipeline register, read-valid strobes and a hardware clear-on-reset sequencer. It succeeds the fixed 32-bit Spartan-6 dual-port BRAM wrapper as the generic on-chip memory for CPU instruction/data RAM and packet buffers. Any width that is a multiple of 8 and any power-of-two depth are supported. Vendor primitives are inferred, not instantiated.

## Interface
- DATA_WIDTH, 32: word width in bits; multiple of 8, 8..128.
- DEPTH, 4096: words; power of two, 16..65536.
- OUT_REG, 0: 1 adds an output pipeline register on both ports.
- CLEAR_ON_RESET, 1: 1 zero-fills the array after every reset.
- Derived constants: AW = clog2(DEPTH), BW = DATA_WIDTH/8.

Ports:
- Clock  in  1  sole clock for both ports.
- Reset  in  1  asynchronous, active-high.
- Busy  out  1  clear sequence in progress; port accesses are ignored while high.
- AddressA, AddressB  in  AW  word address.
- DataInA, DataInB  in  DATA_WIDTH  write data.
- ByteEnA, ByteEnB  in  BW  byte lane write enables; bit i covers bits 8i+7:8i.
- ClockEnA, ClockEnB  in  1  access request.
- WriteA, WriteB  in  1  1 = write, 0 = read; qualified by ClockEn.
- DataOutA, DataOutB  out  DATA_WIDTH  read data.
- ValidA, ValidB  out  1  one-cycle strobe marking new DataOut.

## Operation
- **Reset values:** DataOutA/B = 0, ValidA/B = 0, Busy = CLEAR_ON_RESET. The array content is not reset directly.
- **Clear FSM states:** CLEAR, RUN.
  - Reset forces CLEAR with the counter at 0.
  - In CLEAR, one word is written to 0 per cycle at address = counter, all lanes.
  - At counter = DEPTH-1 the FSM moves to RUN and Busy falls.
  - With CLEAR_ON_RESET = 0 the FSM resets directly into RUN.
- **Reset mid-clear:** the FSM restarts at address 0.
- **Accesses in CLEAR:** all ClockEn/Write inputs are ignored. No writes occur and no Valid strobe is issued.
- **Read** (ClockEn = 1, Write = 0): DataOut is updated and Valid pulses after the read latency.
- **Write** (ClockEn = 1, Write = 1): only lanes with ByteEn set are updated. A write with ByteEn = 0 is a no-op.
  - Read-first: the same port's DataOut shows the pre-write word and Valid pulses.
- **ClockEn = 0:** DataOut holds its last value and Valid = 0.
- **A and B write the same address in the same cycle:**
  - Per lane, port A wins where ByteEnA is set.
  - B's lanes are written only where ByteEnA is clear.
- **One port reads while the other writes the same address:** the read returns the old word.
- **Address width:** exactly AW bits. No wrap or range logic is required.

## Timing
- Read latency: 1 cycle with OUT_REG = 0, 2 cycles with OUT_REG = 1.
  - OUT_REG = 1 pipeline: issue edge n, data valid after edge n+2.
- Throughput: one access per port per cycle, with no stalls in RUN.
- Clear duration:
  - Edge 1 after Reset deasserts writes word 0.
  - Edge DEPTH writes word DEPTH-1 and drops Busy.
  - The first accepted access is sampled at edge DEPTH+1.
- Busy rises asynchronously with Reset.

## Structure
- Package bram_pkg holds:
  - the clog2 function
  - the lane-count helper BW
  - the state enum {CLEAR, RUN}
- Sub-module bram_clear_ctrl owns the FSM and counter. It outputs Busy plus the clear address and write strobe, which are muxed ahead of port A.
- The memory array is a single inferred lane-enabled dual-port memory.
- The output register stage is a generate branch on OUT_REG.

## Test plan
- **Clear:** DEPTH = 16, CLEAR_ON_RESET = 1, array preloaded with 0xFFFFFFFF, reset released → Busy falls after edge 16; reading all 16 addresses returns 0x00000000.
- **Byte enables:** write 0x11223344 to addr 5 with ByteEnA = 4'b1111, then write 0xAABBCCDD with ByteEnA = 4'b0101 → read returns 0x11BB33DD.
- **Collision:** same cycle, A writes 0xAAAAAAAA with ByteEnA = 4'b0011 and B writes 0xBBBBBBBB with ByteEnB = 4'b1111, both to addr 7 → addr 7 reads 0xBBBBAAAA.
- **Read-during-write:** addr 3 holds 0x1; A writes 0x2 to addr 3 while B reads addr 3 → DataOutB = 0x1 and ValidB pulses; the next read returns 0x2.
- **Latency and hold:** with OUT_REG = 1, a read issued at edge n → ValidA high only after edge n+2; DataOutA holds while ClockEnA = 0.
- **Reset mid-clear:** Reset pulsed at counter = 9 → the clear restarts at 0, Busy stays high for a further 16 edges, and accesses made during Busy leave memory unchanged.
